echo_delay_line: RTL

ECHO_DELAY_LINE -- requirements
Module: echo_delay_line

---
 rtl/echo_delay_line.sv | 118 +++++++++++
 1 files changed

// File: rtl/echo_delay_line.sv
// Single-tap echo: y = sat(x + gain * x[n - N]), with the delay history held in an
// external single-port read-first RAM. Each sample is written and its old slot read back in one access.
module echo_delay_line #(
  parameter int DATA_WIDTH  = 16,
  parameter int RAM_DEPTH   = 1024,
  parameter int RAM_LATENCY = 1,
  localparam int AW         = $clog2(RAM_DEPTH)
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic [AW-1:0]         delay_len,
  input  logic [7:0]            gain,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_en,
  output logic                  ram_regce,
  output logic                  ram_rst,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  localparam logic signed [DATA_WIDTH+9:0] SAT_MAX = {{11{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH+9:0] SAT_MIN = {{11{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state, state_d;
  logic [1:0]                     wait_cnt;
  logic [AW-1:0]                  wr_ptr;
  logic [AW:0]                    fill_cnt;
  logic [AW-1:0]                  delay_len_q;
  logic signed [DATA_WIDTH-1:0]   x_q;
  logic                           primed_q;

  logic [AW:0]                    n_eff;
  logic                           dly_change;
  logic                           accept;
  logic                           last_wait;
  logic signed [DATA_WIDTH-1:0]   d_eff;
  logic signed [DATA_WIDTH+8:0]   prod;
  logic signed [DATA_WIDTH+8:0]   scaled;
  logic signed [DATA_WIDTH+9:0]   sum;
  logic [DATA_WIDTH-1:0]          y_sat;

  assign n_eff      = (delay_len_q == '0) ? (AW+1)'(RAM_DEPTH) : {1'b0, delay_len_q};
  assign dly_change = (state == IDLE) && (delay_len != delay_len_q);
  // A delay change steals the IDLE cycle so the pointer restart never races a write.
  assign s_ready    = rsta_n && (state == IDLE) && !dly_change;
  assign accept     = s_ready && s_valid;
  assign m_valid    = (state == OUT);
  assign last_wait  = (state == WAIT) && (wait_cnt == 2'(RAM_LATENCY - 1));

  assign ram_en     = accept;
  assign ram_we     = accept;
  assign ram_addr   = wr_ptr;
  assign ram_din    = s_data;
  assign ram_regce  = 1'b1;
  assign ram_rst    = 1'b0;

  // Until N_eff samples exist the slot holds stale data, so the echo term is masked.
  assign d_eff  = primed_q ? $signed(ram_dout) : '0;
  assign prod   = (DATA_WIDTH+9)'(d_eff) * (DATA_WIDTH+9)'($signed({1'b0, gain}));
  assign scaled = prod >>> 7;
  assign sum    = (DATA_WIDTH+10)'(x_q) + (DATA_WIDTH+10)'(scaled);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y_sat = sum[DATA_WIDTH-1:0];
    if (sum > SAT_MAX)      y_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum < SAT_MIN) y_sat = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept)    state_d = WAIT;
      WAIT:    if (last_wait) state_d = OUT;
      OUT:     if (m_ready)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the delay RAM itself is never cleared; fill_cnt = 0 masks whatever it holds.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      delay_len_q <= '0;
      x_q         <= '0;
      primed_q    <= 1'b0;
      m_data      <= '0;
    end else begin
      state <= state_d;
      if (dly_change) begin
        delay_len_q <= delay_len;
        wr_ptr      <= '0;
        fill_cnt    <= '0;
      end else if (accept) begin
        wr_ptr   <= ({1'b0, wr_ptr} == n_eff - (AW+1)'(1)) ? '0 : wr_ptr + 1'b1;
        if (fill_cnt != n_eff) fill_cnt <= fill_cnt + (AW+1)'(1);
        x_q      <= $signed(s_data);
        primed_q <= (fill_cnt == n_eff);
      end
      wait_cnt <= ((state == WAIT) && !last_wait) ? wait_cnt + 2'd1 : 2'd0;
      if (last_wait) m_data <= y_sat;
    end
  end

endmodule
